// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and widths for the data memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int MEM_DATA_W = 16;
  localparam int MEM_ADDR_W = 16;
  localparam int MEM_WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Brief    : Single-port DEPTHx16 storage, synchronous write and registered read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic                     i_re,
  input  logic                     i_clr,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [MEM_DATA_W-1:0]    i_wdata,
  output logic [MEM_DATA_W-1:0]    o_rdata
);

  logic [MEM_DATA_W-1:0] r_mem [DEPTH];
  logic [MEM_DATA_W-1:0] r_rdata;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_clr ? '0 : r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Load/store responder with WAIT_CYCLES wait states per access.
//            Define MEM_RANGE_CHECK_EN to flag and suppress addr >= DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  write_enable,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_DATA_W-1:0] data_in,
  output logic [MEM_DATA_W-1:0] mem_data_out,
  output logic                  resp_valid,
  output logic                  err
);

  localparam int c_idx_w = $clog2(DEPTH);
  localparam logic [MEM_WAIT_W-1:0] c_wait_load =
    (WAIT_CYCLES > 0) ? MEM_WAIT_W'(WAIT_CYCLES - 1) : '0;

  mem_state_t            r_state;
  mem_state_t            w_next;
  logic [MEM_WAIT_W-1:0] r_cnt;
  logic                  r_we;
  logic                  r_oor;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [MEM_DATA_W-1:0] r_data;

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_sel_we;
  logic                  w_sel_oor;
  logic [MEM_ADDR_W-1:0] w_sel_addr;
  logic [MEM_DATA_W-1:0] w_sel_data;
  logic                  w_unused_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            w_next       = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_we   <= 1'b0;
      r_oor  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_accept) begin
      r_cnt  <= c_wait_load;
      r_we   <= write_enable;
      r_oor  <= w_sel_oor;
      r_addr <= addr;
      r_data <= data_in;
    end else if (r_state == WAIT && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // With zero wait states the array is touched on the accept edge itself,
  // before the payload registers hold the request, so use the live inputs.
  assign w_sel_we   = (r_state == IDLE) ? write_enable : r_we;
  assign w_sel_addr = (r_state == IDLE) ? addr         : r_addr;
  assign w_sel_data = (r_state == IDLE) ? data_in      : r_data;

`ifdef MEM_RANGE_CHECK_EN
  generate
    if (c_idx_w < MEM_ADDR_W) begin : g_oor_chk
      assign w_sel_oor = |w_sel_addr[MEM_ADDR_W-1:c_idx_w];
    end else begin : g_oor_none
      assign w_sel_oor = 1'b0;
    end
  endgenerate
`else
  assign w_sel_oor = 1'b0;
`endif

  assign w_unused_hi = ^w_sel_addr;
  assign err         = resp_valid & r_oor;

  mem_array #(
    .DEPTH(DEPTH)
  ) u_mem_array (
    .clk    (clk),
    .rst    (rst),
    .i_we   (w_enter_resp & w_sel_we & ~w_sel_oor),
    .i_re   (w_enter_resp & ~w_sel_we),
    .i_clr  (w_sel_oor),
    .i_addr (w_sel_addr[c_idx_w-1:0]),
    .i_wdata(w_sel_data),
    .o_rdata(mem_data_out)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Directed bench over four responders with WAIT_CYCLES 1, 3, 0, 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid    [4];
  logic        req_ready    [4];
  logic        write_enable [4];
  logic [15:0] addr         [4];
  logic [15:0] data_in      [4];
  logic [15:0] mem_data_out [4];
  logic        resp_valid   [4];
  logic        err          [4];

  int n_checks = 0;
  int n_errors = 0;
  int err_bad  = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .write_enable(write_enable[0]), .addr(addr[0]), .data_in(data_in[0]),
    .mem_data_out(mem_data_out[0]), .resp_valid(resp_valid[0]), .err(err[0]));
  mem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .write_enable(write_enable[1]), .addr(addr[1]), .data_in(data_in[1]),
    .mem_data_out(mem_data_out[1]), .resp_valid(resp_valid[1]), .err(err[1]));
  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .write_enable(write_enable[2]), .addr(addr[2]), .data_in(data_in[2]),
    .mem_data_out(mem_data_out[2]), .resp_valid(resp_valid[2]), .err(err[2]));
  mem_responder #(.DEPTH(256), .WAIT_CYCLES(4)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[3]), .req_ready(req_ready[3]),
    .write_enable(write_enable[3]), .addr(addr[3]), .data_in(data_in[3]),
    .mem_data_out(mem_data_out[3]), .resp_valid(resp_valid[3]), .err(err[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge; returns one falling edge past the response.
  task automatic access(input int d, input logic we, input logic [15:0] a,
                        input logic [15:0] din, output int lat,
                        output logic [15:0] dout, output logic e);
    int n;
    req_valid[d]    = 1'b1;
    write_enable[d] = we;
    addr[d]         = a;
    data_in[d]      = din;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    lat = 1;
    while (!resp_valid[d] && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    dout = mem_data_out[d];
    e    = err[d];
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_RANGE_CHECK_EN
        if (err[i] && !resp_valid[i]) err_bad++;
`else
        if (err[i]) err_bad++;
`endif
      end
    end
  end

  initial begin
    int          lat;
    logic [15:0] dout;
    logic        e;
    logic [14:0] rdy15, rsp15;
    logic [5:0]  rdy6, rsp6;
    int          rsp_cnt;

    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid[i]    = 1'b0;
      write_enable[i] = 1'b0;
      addr[i]         = 16'h0000;
      data_in[i]      = 16'h0000;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("rst_resp%0d", i),  32'(resp_valid[i]), 32'd0);
      check($sformatf("rst_data%0d", i),  32'(mem_data_out[i]), 32'h0000);
      check($sformatf("rst_err%0d", i),   32'(err[i]), 32'd0);
    end

    // WAIT_CYCLES=1: store then load
    access(0, 1'b1, 16'd5, 16'hBEEF, lat, dout, e);
    check("w1_store_lat", 32'(lat), 32'd2);
    check("w1_store_err", 32'(e), 32'd0);
    access(0, 1'b0, 16'd5, 16'h0000, lat, dout, e);
    check("w1_load_lat", 32'(lat), 32'd2);
    check("w1_load_data", 32'(dout), 32'hBEEF);

    // WAIT_CYCLES=3: back-to-back with req_valid held high
    req_valid[1] = 1'b1; write_enable[1] = 1'b0; addr[1] = 16'd0;
    for (int i = 0; i < 15; i++) begin
      rdy15[i] = req_ready[1];
      rsp15[i] = resp_valid[1];
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    check("w3_ready_pattern", 32'(rdy15), 32'(15'b000010000100001));
    check("w3_resp_pattern",  32'(rsp15), 32'(15'b100001000010000));
    @(negedge clk);

    // WAIT_CYCLES=0: immediate response, accept every 2 cycles
    access(2, 1'b1, 16'd0, 16'h1234, lat, dout, e);
    check("w0_store_lat", 32'(lat), 32'd1);
    access(2, 1'b0, 16'd0, 16'h0000, lat, dout, e);
    check("w0_load_lat", 32'(lat), 32'd1);
    check("w0_load_data", 32'(dout), 32'h1234);
    req_valid[2] = 1'b1; write_enable[2] = 1'b0; addr[2] = 16'd0;
    for (int i = 0; i < 6; i++) begin
      rdy6[i] = req_ready[2];
      rsp6[i] = resp_valid[2];
      @(negedge clk);
    end
    req_valid[2] = 1'b0;
    check("w0_ready_pattern", 32'(rdy6), 32'(6'b010101));
    check("w0_resp_pattern",  32'(rsp6), 32'(6'b101010));
    @(negedge clk);

    // Range handling on addr 300 (aliases to 44 when DEPTH=256)
    access(0, 1'b1, 16'd44, 16'h4444, lat, dout, e);
    check("rng_pre_err", 32'(e), 32'd0);
    access(0, 1'b1, 16'd300, 16'h0F0F, lat, dout, e);
`ifdef MEM_RANGE_CHECK_EN
    check("rng_store300_err", 32'(e), 32'd1);
`else
    check("rng_store300_err", 32'(e), 32'd0);
`endif
    access(0, 1'b0, 16'd44, 16'h0000, lat, dout, e);
`ifdef MEM_RANGE_CHECK_EN
    check("rng_load44_data", 32'(dout), 32'h4444);
`else
    check("rng_load44_data", 32'(dout), 32'h0F0F);
`endif
    check("rng_load44_err", 32'(e), 32'd0);
    access(0, 1'b0, 16'd300, 16'h0000, lat, dout, e);
`ifdef MEM_RANGE_CHECK_EN
    check("rng_load300_data", 32'(dout), 32'h0000);
    check("rng_load300_err", 32'(e), 32'd1);
`else
    check("rng_load300_data", 32'(dout), 32'h0F0F);
    check("rng_load300_err", 32'(e), 32'd0);
`endif

    // WAIT_CYCLES=4: reset during WAIT aborts the store
    access(3, 1'b1, 16'd7, 16'h5555, lat, dout, e);
    check("w4_store_lat", 32'(lat), 32'd5);
    access(3, 1'b0, 16'd7, 16'h0000, lat, dout, e);
    check("w4_load_data", 32'(dout), 32'h5555);
    req_valid[3] = 1'b1; write_enable[3] = 1'b1; addr[3] = 16'd7; data_in[3] = 16'hAAAA;
    @(negedge clk);
    req_valid[3] = 1'b0;
    rsp_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_ready", 32'(req_ready[3]), 32'd1);
    check("abort_resp",  32'(resp_valid[3]), 32'd0);
    check("abort_data",  32'(mem_data_out[3]), 32'h0000);
    check("abort_err",   32'(err[3]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (resp_valid[3]) rsp_cnt++;
      @(negedge clk);
    end
    check("abort_no_resp", 32'(rsp_cnt), 32'd0);
    access(3, 1'b0, 16'd7, 16'h0000, lat, dout, e);
    check("abort_load_data", 32'(dout), 32'h5555);

    check("err_outside_resp", 32'(err_bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
